// File: rtl/tone_dir_decoder_pkg.sv
// Shared codes for the tone direction decoder: direction codes, band limits and FSM states.
// The drive controller imports the same definitions.
package tone_dir_decoder_pkg;

  typedef enum logic [2:0] {
    TD_HOLD    = 3'd0,
    TD_FORWARD = 3'd1,
    TD_LEFT    = 3'd2,
    TD_RIGHT   = 3'd3,
    TD_REVERSE = 3'd4,
    TD_STOP    = 3'd6
  } tone_dir_e;

  typedef enum logic [1:0] {
    T_IDLE     = 2'd0,
    T_MEASURE  = 2'd1,
    T_CLASSIFY = 2'd2,
    T_LOCKED   = 2'd3
  } tone_state_e;

  localparam int unsigned TB_FWD_LO = 7;
  localparam int unsigned TB_FWD_HI = 13;
  localparam int unsigned TB_LFT_LO = 17;
  localparam int unsigned TB_LFT_HI = 23;
  localparam int unsigned TB_RGT_LO = 27;
  localparam int unsigned TB_RGT_HI = 33;
  localparam int unsigned TB_REV_LO = 37;
  localparam int unsigned TB_REV_HI = 43;
  localparam int unsigned TB_STP_LO = 47;
  localparam int unsigned TB_STP_HI = 53;

  // Inclusive band limits; the gaps between bands deliberately decode to no band.
  function automatic tone_dir_e band_of(input logic [31:0] cnt);
    if (cnt >= TB_FWD_LO && cnt <= TB_FWD_HI) return TD_FORWARD;
    if (cnt >= TB_LFT_LO && cnt <= TB_LFT_HI) return TD_LEFT;
    if (cnt >= TB_RGT_LO && cnt <= TB_RGT_HI) return TD_RIGHT;
    if (cnt >= TB_REV_LO && cnt <= TB_REV_HI) return TD_REVERSE;
    if (cnt >= TB_STP_LO && cnt <= TB_STP_HI) return TD_STOP;
    return TD_HOLD;
  endfunction

endpackage

// File: rtl/tone_dir_decoder_if.sv
// Request/tone inputs and decoded direction outputs between drive controller and decoder.
interface tone_dir_decoder_if
  import tone_dir_decoder_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             enableToneDetection;
  logic             toneIn;
  tone_dir_e        toneDir;
  logic             toneLocked;
  logic [CNT_W-1:0] lastCount;

  modport master (
    output enableToneDetection,
    output toneIn,
    input  toneDir,
    input  toneLocked,
    input  lastCount
  );

  modport slave (
    input  enableToneDetection,
    input  toneIn,
    output toneDir,
    output toneLocked,
    output lastCount
  );
endinterface

// File: rtl/tone_window_counter.sv
// Synchronizes the tone, detects rising edges and counts them over a fixed gate window.
// The edge count saturates; an edge on the window boundary counts into the new window.
module tone_window_counter #(
  parameter int GATE_CYCLES = 500_000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             tone_i,
  output logic             win_done_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);

  logic [2:0]       sync_q;
  logic             pulse_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edges_q, edges_d;
  logic             win_done;

  // sync_q[1:0] is the metastability chain, sync_q[2] the previous sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], tone_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign win_done = run_i && (win_q == WIN_LAST);

  always_comb begin
    win_d   = win_q;
    edges_d = edges_q;
    if (!run_i) begin
      win_d   = '0;
      edges_d = '0;
    end else if (win_done) begin
      win_d   = '0;
      edges_d = pulse_q ? CNT_W'(1) : '0;
    end else begin
      win_d = win_q + 1'b1;
      if (pulse_q && (edges_q != '1)) edges_d = edges_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q   <= '0;
      edges_q <= '0;
    end else begin
      win_q   <= win_d;
      edges_q <= edges_d;
    end
  end

  assign win_done_o = win_done;
  assign count_o    = edges_q;

endmodule

// File: rtl/tone_dir_decoder.sv
// Maps the per-window tone edge count to a direction band and reports it once
// CONFIRM_WINDOWS consecutive windows agree; dropping the enable returns to TD_HOLD.
module tone_dir_decoder
  import tone_dir_decoder_pkg::*;
#(
  parameter int GATE_CYCLES     = 500_000,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  tone_dir_decoder_if.slave  bus
);
  localparam logic [3:0] CONFIRM = 4'(CONFIRM_WINDOWS);

  tone_state_e      state_q, state_d;
  tone_dir_e        cand_q, cand_d;
  tone_dir_e        dir_q, dir_d;
  tone_dir_e        band;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] last_q;
  logic [CNT_W-1:0] count;
  logic             win_done;
  logic             run;

  // The next window keeps counting while the finished one is classified.
  assign run = (state_q == T_MEASURE) || (state_q == T_CLASSIFY);

  tone_window_counter #(
    .GATE_CYCLES (GATE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .tone_i     (bus.toneIn),
    .win_done_o (win_done),
    .count_o    (count)
  );

  assign band = band_of(32'(last_q));

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    unique case (state_q)
      T_IDLE: begin
        dir_d    = TD_HOLD;
        locked_d = 1'b0;
        cand_d   = TD_HOLD;
        match_d  = '0;
        if (bus.enableToneDetection) state_d = T_MEASURE;
      end
      T_MEASURE: begin
        if (win_done) state_d = T_CLASSIFY;
      end
      T_CLASSIFY: begin
        if (band == TD_HOLD) begin
          cand_d  = TD_HOLD;
          match_d = '0;
        end else if (band != cand_q) begin
          cand_d  = band;
          match_d = 4'd1;
        end else if (match_q != 4'hF) begin
          match_d = match_q + 4'd1;
        end
        if (match_d == CONFIRM) begin
          state_d  = T_LOCKED;
          dir_d    = cand_d;
          locked_d = 1'b1;
        end else begin
          state_d = T_MEASURE;
        end
      end
      T_LOCKED: begin
      end
    endcase
    // Losing the request wins over any window result arriving on the same cycle.
    if (!bus.enableToneDetection) begin
      state_d  = T_IDLE;
      dir_d    = TD_HOLD;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= T_IDLE;
      cand_q   <= TD_HOLD;
      match_q  <= '0;
      dir_q    <= TD_HOLD;
      locked_q <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      if (win_done) last_q <= count;
    end
  end

  assign bus.toneDir    = dir_q;
  assign bus.toneLocked = locked_q;
  assign bus.lastCount  = last_q;

endmodule

// File: tb/tb_tone_dir_decoder.sv
// Bench for tone_dir_decoder: output changes are matched against a queue of expected
// (direction, lock, cycle) events; counts and steady states are checked in line.
module tb_tone_dir_decoder;
  import tone_dir_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tone_dir_decoder_if #(.CNT_W(16)) bus_a ();
  tone_dir_decoder_if #(.CNT_W(8))  bus_b ();

  tone_dir_decoder #(.GATE_CYCLES(1000), .CONFIRM_WINDOWS(3), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  // Narrow count so saturation is reachable inside one short window.
  tone_dir_decoder #(.GATE_CYCLES(1000), .CONFIRM_WINDOWS(3), .CNT_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int per_a = 0;
  logic fast_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] dir;
    logic       lock;
    int         at;
    string      tag;
  } exp_t;
  exp_t expq[$];

  // Tone generator for DUT A: square wave with a period in clk cycles, rising at period start.
  initial begin
    bus_a.toneIn = 1'b0;
    forever begin
      int p;
      p = per_a;
      if (p < 2) begin
        bus_a.toneIn = 1'b0;
        @(negedge clk);
      end else begin
        bus_a.toneIn = 1'b1;
        repeat (p / 2) @(negedge clk);
        bus_a.toneIn = 1'b0;
        repeat (p - p / 2) @(negedge clk);
      end
    end
  end

  initial begin
    bus_b.toneIn = 1'b0;
    forever begin
      @(negedge clk);
      bus_b.toneIn = fast_b ? ~bus_b.toneIn : 1'b0;
    end
  end

  // Monitor: every change on DUT A's decoded outputs must match the next queued expectation.
  initial begin
    logic [2:0] prev_dir;
    logic       prev_lock;
    exp_t       e;
    prev_dir  = 3'd0;
    prev_lock = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.toneDir !== prev_dir || bus_a.toneLocked !== prev_lock) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got dir=%0d lock=%0d at cyc %0d, required no change",
                   bus_a.toneDir, bus_a.toneLocked, cyc);
        end else begin
          e = expq.pop_front();
          if (bus_a.toneDir !== e.dir || bus_a.toneLocked !== e.lock || (e.at >= 0 && cyc != e.at)) begin
            bad++;
            $display("FAIL %s: got dir=%0d lock=%0d cyc=%0d, required dir=%0d lock=%0d cyc=%0d",
                     e.tag, bus_a.toneDir, bus_a.toneLocked, cyc, e.dir, e.lock, e.at);
          end
        end
        prev_dir  = bus_a.toneDir;
        prev_lock = bus_a.toneLocked;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask

  task automatic push(input logic [2:0] dir, input logic lock, input int at, input string tag);
    exp_t e;
    e.dir = dir; e.lock = lock; e.at = at; e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending events required 0", nm, expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic drop_enable(input string tag);
    @(negedge clk);
    push(3'd0, 1'b0, cyc + 1, tag);
    bus_a.enableToneDetection = 1'b0;
    drain(tag, 10);
  endtask

  initial begin
    int n;
    bus_a.enableToneDetection = 1'b0;
    bus_b.enableToneDetection = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dir", 32'(bus_a.toneDir), 0);
    chk("rst_lock", 32'(bus_a.toneLocked), 0);
    chk("rst_count", 32'(bus_a.lastCount), 0);
    chk("rst_count_b", 32'(bus_b.lastCount), 0);
    rst = 1'b1;

    // Steady 10-edge tone: forward lock exactly 3002 cycles after enable.
    per_a = 100;
    repeat (200) @(negedge clk);
    n = cyc;
    push(3'd1, 1'b1, n + 3002, "t1_lock_fwd");
    bus_a.enableToneDetection = 1'b1;
    repeat (1002) @(negedge clk);
    chk("t1_count_w1", 32'(bus_a.lastCount), 10);
    chk("t1_unlocked_w1", 32'(bus_a.toneLocked), 0);
    drain("t1_lock_fwd", 2500);
    chk("t1_count_locked", 32'(bus_a.lastCount), 10);
    drop_enable("t1_drop");

    // Enable removed on the very cycle that would lock: no lock may appear.
    repeat (5) @(negedge clk);
    n = cyc;
    bus_a.enableToneDetection = 1'b1;
    repeat (3001) @(negedge clk);
    bus_a.enableToneDetection = 1'b0;
    repeat (10) @(negedge clk);
    chk("t7_prio_lock", 32'(bus_a.toneLocked), 0);
    chk("t7_prio_dir", 32'(bus_a.toneDir), 0);

    // Two 20-edge windows then a 40-edge tone: candidate restarts, reverse lock, never left.
    per_a = 50;
    repeat (100) @(negedge clk);
    n = cyc;
    push(3'd4, 1'b1, n + 5002, "t2_lock_rev");
    bus_a.enableToneDetection = 1'b1;
    repeat (1002) @(negedge clk);
    chk("t2_count_w1", 32'(bus_a.lastCount), 20);
    repeat (998) @(negedge clk);
    per_a = 25;
    drain("t2_lock_rev", 3200);
    chk("t2_count_locked", 32'(bus_a.lastCount), 40);
    drop_enable("t2_drop");

    // 15-edge tone sits between bands: ten windows with no lock.
    per_a = 66;
    repeat (100) @(negedge clk);
    bus_a.enableToneDetection = 1'b1;
    repeat (10010) @(negedge clk);
    chk("t3_dir_hold", 32'(bus_a.toneDir), 0);
    chk("t3_unlocked", 32'(bus_a.toneLocked), 0);
    chk("t3_count_gap", 32'(bus_a.lastCount == 16'd15 || bus_a.lastCount == 16'd16), 1);
    @(negedge clk);
    bus_a.enableToneDetection = 1'b0;
    repeat (5) @(negedge clk);

    // Lock on right, then change the tone: the locked code stays frozen.
    per_a = 33;
    repeat (100) @(negedge clk);
    n = cyc;
    push(3'd3, 1'b1, n + 3002, "t4_lock_right");
    bus_a.enableToneDetection = 1'b1;
    drain("t4_lock_right", 3200);
    per_a = 20;
    repeat (3100) @(negedge clk);
    chk("t4_frozen_dir", 32'(bus_a.toneDir), 3);
    chk("t4_frozen_lock", 32'(bus_a.toneLocked), 1);
    drop_enable("t4_drop");

    // Lock on stop, async reset mid-window, then relock from scratch.
    repeat (100) @(negedge clk);
    n = cyc;
    push(3'd6, 1'b1, n + 3002, "t6_lock_stop");
    bus_a.enableToneDetection = 1'b1;
    drain("t6_lock_stop", 3200);
    repeat (500) @(negedge clk);
    push(3'd0, 1'b0, -1, "t6_rst_clear");
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_dir", 32'(bus_a.toneDir), 0);
    chk("t6_rst_lock", 32'(bus_a.toneLocked), 0);
    chk("t6_rst_count", 32'(bus_a.lastCount), 0);
    repeat (3) @(negedge clk);
    n = cyc;
    push(3'd6, 1'b1, n + 3002, "t6_relock_stop");
    rst = 1'b1;
    drain("t6_relock_stop", 3200);
    chk("t6_count", 32'(bus_a.lastCount), 50);
    drop_enable("t6_drop");
    per_a = 0;

    // Edge every other clock: 500 edges saturate the 8-bit count instead of wrapping.
    fast_b = 1'b1;
    repeat (10) @(negedge clk);
    bus_b.enableToneDetection = 1'b1;
    repeat (1002) @(negedge clk);
    chk("t5_sat_w1", 32'(bus_b.lastCount), 255);
    repeat (3000) @(negedge clk);
    chk("t5_sat_w4", 32'(bus_b.lastCount), 255);
    chk("t5_dir_hold", 32'(bus_b.toneDir), 0);
    chk("t5_unlocked", 32'(bus_b.toneLocked), 0);
    bus_b.enableToneDetection = 1'b0;
    fast_b = 1'b0;
    repeat (10) @(negedge clk);

    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_events: got %0d pending required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by cyc %0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
